inst_mem_loader: RTL and testbench



---
 rtl/inst_mem_loader.sv | 127 ++++++++++++
 tb/tb_inst_mem_loader.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_loader.sv
// Boot loader: UART byte stream {N_hi, N_lo, 4*N big-endian bytes} -> instruction RAM writes.
// One-cycle write latency after each 4th byte; no backpressure, so every rx_valid strobe is consumed.
module inst_mem_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0040_0000,
    parameter int          RAM_ADDR_WIDTH = 9,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    reload,
    output logic                    wr_en,
    output logic [31:0]             wr_addr,
    output logic [31:0]             wr_data,
    output logic                    cpu_hold,
    output logic                    done,
    output logic                    error,
    output logic [RAM_ADDR_WIDTH:0] words_written
);

    localparam logic [16:0] MAX_WORDS = 17'(2 ** RAM_ADDR_WIDTH);

    typedef enum logic [2:0] {
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state, state_d;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [23:0] asm_q;
    logic [1:0]  byte_cnt;
    logic [23:0] tmo_cnt;

    logic [15:0] len_rx;
    logic        len_bad;
    logic        tmo_active;
    logic        tmo_hit;
    logic        word_last;
    logic        restart;

    always_comb begin
        len_rx     = {len_hi, rx_data};
        len_bad    = (len_rx == 16'd0) || ({1'b0, len_rx} > MAX_WORDS);
        tmo_active = (state == S_LEN_LO) || (state == S_DATA);
        tmo_hit    = tmo_active && !rx_valid && ((tmo_cnt + 24'd1) == TIMEOUT_CYCLES);
        word_last  = (state == S_DATA) && rx_valid && (byte_cnt == 2'd3);
        restart    = reload && ((state == S_DONE) || (state == S_ERROR));
        state_d    = state;

        case (state)
            S_LEN_HI: begin
                if (rx_valid) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_valid)     state_d = len_bad ? S_ERROR : S_DATA;
                else if (tmo_hit) state_d = S_ERROR;
            end
            S_DATA: begin
                // Leave only once the final write pulse is on the port, so done follows it.
                if (wr_en && (16'(words_written) == len)) state_d = S_DONE;
                else if (tmo_hit)                          state_d = S_ERROR;
            end
            S_DONE, S_ERROR: begin
                if (restart) state_d = S_LEN_HI;
            end
            default: state_d = S_LEN_HI;
        endcase

        done     = (state == S_DONE);
        error    = (state == S_ERROR);
        cpu_hold = (state != S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_LEN_HI;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en         <= 1'b0;
            wr_addr       <= BASE_ADDR;
            wr_data       <= 32'd0;
            words_written <= '0;
            len_hi        <= 8'd0;
            len           <= 16'd0;
            asm_q         <= 24'd0;
            byte_cnt      <= 2'd0;
            tmo_cnt       <= 24'd0;
        end else begin
            wr_en <= word_last;

            if (!tmo_active || rx_valid) tmo_cnt <= 24'd0;
            else                         tmo_cnt <= tmo_cnt + 24'd1;

            if ((state == S_LEN_HI) && rx_valid) len_hi <= rx_data;

            // A fresh length always starts word assembly from byte 0, dropping any stale partial.
            if ((state == S_LEN_LO) && rx_valid) begin
                len      <= len_rx;
                byte_cnt <= 2'd0;
            end

            if ((state == S_DATA) && rx_valid) begin
                asm_q    <= {asm_q[15:0], rx_data};
                byte_cnt <= byte_cnt + 2'd1;
            end

            if (word_last) begin
                wr_data       <= {asm_q, rx_data};
                wr_addr       <= BASE_ADDR + 32'({words_written, 2'b00});
                words_written <= words_written + 1'b1;
            end

            if (restart) begin
                words_written <= '0;
                wr_addr       <= BASE_ADDR;
            end
        end
    end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Bench for inst_mem_loader: byte-count reference model checked every cycle plus literal spot checks.
module tb_inst_mem_loader;

    localparam int          T    = 100;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        reload;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [9:0]  words_written;

    inst_mem_loader #(
        .BASE_ADDR     (BASE),
        .RAM_ADDR_WIDTH(9),
        .TIMEOUT_CYCLES(24'd100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .reload       (reload),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: tracks the frame by counting received bytes.
    bit          m_ok = 1'b0;
    bit          m_err, m_done, m_pend, e_wr;
    logic [31:0] e_addr, e_data, m_word;
    int          m_bytes, m_n, m_idle, e_ww;

    always @(posedge clk) begin
        e_wr = 1'b0;
        if (reset) begin
            m_ok = 1'b1; m_err = 1'b0; m_done = 1'b0; m_pend = 1'b0;
            e_addr = BASE; e_data = 32'd0; m_word = 32'd0;
            e_ww = 0; m_bytes = 0; m_n = 0; m_idle = 0;
        end else if (m_ok) begin
            if (m_pend) begin
                m_pend = 1'b0;
                m_done = 1'b1;
            end else if (m_done || m_err) begin
                if (reload) begin
                    m_done = 1'b0; m_err = 1'b0; e_ww = 0; e_addr = BASE;
                    m_bytes = 0; m_idle = 0;
                end
            end else if (rx_valid) begin
                m_idle = 0;
                if (m_bytes == 0) begin
                    m_n = int'(rx_data) * 256;
                end else if (m_bytes == 1) begin
                    m_n += int'(rx_data);
                    if (m_n == 0 || m_n > 512) m_err = 1'b1;
                end else begin
                    m_word = {m_word[23:0], rx_data};
                    if ((m_bytes - 2) % 4 == 3) begin
                        e_wr   = 1'b1;
                        e_addr = BASE + 32'(4 * e_ww);
                        e_data = m_word;
                        e_ww++;
                        if (e_ww == m_n) m_pend = 1'b1;
                    end
                end
                m_bytes++;
            end else if (m_bytes > 0) begin
                m_idle++;
                if (m_idle == T) m_err = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("wr_en",         wr_en,         e_wr);
            chk("wr_addr",       wr_addr,       e_addr);
            chk("wr_data",       wr_data,       e_data);
            chk("done",          done,          m_done);
            chk("error",         error,         m_err);
            chk("cpu_hold",      cpu_hold,      !m_done);
            chk("words_written", words_written, e_ww);
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];
    wr_t w_tmp;

    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            w_tmp.a = wr_addr;
            w_tmp.d = wr_data;
            wlog.push_back(w_tmp);
        end
    end

    typedef logic [7:0] bq_t[$];

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        reload   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            rx_valid = 1'b0;
            reload   = 1'b0;
            reset    = 1'b0;
        end
    endtask

    task automatic send_gapped(input bq_t q);
        foreach (q[i]) begin
            send(q[i]);
            idle(1);
        end
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        rx_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
    endtask

    bq_t frame2, frame1, q;

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; reload = 1'b0;
        frame2 = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h40, 8'h00, 8'h34, 8'h30, 8'h00, 8'h18};
        frame1 = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        repeat (2) @(negedge clk);
        idle(2);
        chk("rst_cpu_hold", cpu_hold, 32'd1);
        chk("rst_wr_addr",  wr_addr,  32'h0040_0000);
        chk("rst_ww",       words_written, 32'd0);

        // Normal two-word load
        wlog.delete();
        send_gapped(frame2);
        idle(3);
        chk("norm_nwr",   wlog.size(), 32'd2);
        chk("norm_a0",    wlog[0].a, 32'h0040_0000);
        chk("norm_d0",    wlog[0].d, 32'h3C01_4000);
        chk("norm_a1",    wlog[1].a, 32'h0040_0004);
        chk("norm_d1",    wlog[1].d, 32'h3430_0018);
        chk("norm_done",  done,      32'd1);
        chk("norm_hold",  cpu_hold,  32'd0);

        // Bytes after done are ignored
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_gapped(q);
        idle(2);
        chk("post_nwr", wlog.size(), 32'd2);
        chk("post_ww",  words_written, 32'd2);

        // Zero length, then recover with a one-word frame
        pulse_reload();
        wlog.delete();
        q = '{8'h00, 8'h00};
        send_gapped(q);
        idle(3);
        chk("len0_err", error, 32'd1);
        chk("len0_nwr", wlog.size(), 32'd0);
        pulse_reload();
        send_gapped(frame1);
        idle(3);
        chk("rec_done", done, 32'd1);
        chk("rec_d0",   wlog[0].d, 32'hDEAD_BEEF);
        chk("rec_a0",   wlog[0].a, 32'h0040_0000);

        // N = 513 is one word too many
        pulse_reload();
        q = '{8'h02, 8'h01};
        send_gapped(q);
        idle(3);
        chk("len513_err", error, 32'd1);

        // Timeout with a partial word
        pulse_reload();
        wlog.delete();
        send(8'h00); send(8'h01); send(8'h3C); send(8'h01);
        idle(T + 5);
        chk("tmo_err",  error,    32'd1);
        chk("tmo_hold", cpu_hold, 32'd1);
        chk("tmo_nwr",  wlog.size(), 32'd0);
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_gapped(q);
        idle(2);
        chk("tmo_ign_nwr", wlog.size(), 32'd0);
        chk("tmo_ign_err", error, 32'd1);

        // Reset mid-load after one word went out
        pulse_reload();
        q = '{8'h00, 8'h02, 8'h3C, 8'h01, 8'h40, 8'h00};
        send_gapped(q);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_addr", wr_addr,       32'h0040_0000);
        chk("mrst_data", wr_data,       32'd0);
        chk("mrst_ww",   words_written, 32'd0);
        chk("mrst_hold", cpu_hold,      32'd1);
        idle(2);
        wlog.delete();
        send_gapped(frame2);
        idle(3);
        chk("mrst_a0",   wlog[0].a, 32'h0040_0000);
        chk("mrst_d1",   wlog[1].d, 32'h3430_0018);
        chk("mrst_done", done, 32'd1);

        // Reload during DATA is ignored
        pulse_reload();
        wlog.delete();
        send(8'h00); send(8'h01); send(8'h11); send(8'h22);
        pulse_reload();
        send(8'h33); send(8'h44);
        idle(3);
        chk("midrl_nwr",  wlog.size(), 32'd1);
        chk("midrl_d0",   wlog[0].d, 32'h1122_3344);
        chk("midrl_done", done, 32'd1);

        // Full-depth back-to-back stream
        pulse_reload();
        wlog.delete();
        send(8'h02); send(8'h00);
        for (int i = 0; i < 2048; i++) send(8'(i * 7 + 3));
        idle(3);
        chk("b2b_nwr",   wlog.size(), 32'd512);
        chk("b2b_d0",    wlog[0].d,   32'h030A_1118);
        chk("b2b_alast", wlog[511].a, 32'h0040_07FC);
        chk("b2b_dlast", wlog[511].d, 32'hE7EE_F5FC);
        chk("b2b_ww",    words_written, 32'd512);
        chk("b2b_done",  done, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
